// File: rtl/sha256_message_build_if.sv
// Bundles the config, message-word and padded-block handshakes of the SHA-256 message builder.
// The slave view is the builder; the master view is whoever feeds it and drains its blocks.
interface sha256_message_build_if;
  logic [63:0]  cfg_in_size;
  logic [5:0]   cfg_in_id;
  logic         cfg_in_last;
  logic         cfg_in_valid;
  logic         cfg_in_ready;
  logic [511:0] data_in;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic [5:0]   data_out_id;
  logic         data_out_last;
  logic         data_out_cfg_last;
  logic         data_out_valid;
  logic         data_out_ready;
  logic         err;

  modport slave (
    input  cfg_in_size, cfg_in_id, cfg_in_last, cfg_in_valid,
    output cfg_in_ready,
    input  data_in, data_in_last, data_in_valid,
    output data_in_ready,
    output data_out, data_out_id, data_out_last, data_out_cfg_last, data_out_valid,
    input  data_out_ready,
    output err
  );

  modport master (
    output cfg_in_size, cfg_in_id, cfg_in_last, cfg_in_valid,
    input  cfg_in_ready,
    output data_in, data_in_last, data_in_valid,
    input  data_in_ready,
    input  data_out, data_out_id, data_out_last, data_out_cfg_last, data_out_valid,
    output data_out_ready,
    input  err
  );
endinterface

// File: rtl/sha256_message_build.sv
// Turns one config beat plus the raw 512-bit message words into FIPS 180-4 padded blocks,
// each tagged with the owning message id, through a single output register.
module sha256_message_build (
  input  logic                   clk,
  input  logic                   sync_rst,
  sha256_message_build_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, PAD_ONE, PAD_LEN} state_e;

  state_e       state_q, state_d;
  logic [63:0]  size_q, size_d;
  logic [5:0]   id_q, id_d;
  logic         cfgLast_q, cfgLast_d;
  logic [54:0]  words_q, words_d;

  logic [511:0] outData_q, outData_d;
  logic [5:0]   outId_q, outId_d;
  logic         outLast_q, outLast_d;
  logic         outCfgLast_q, outCfgLast_d;
  logic         outValid_q, outValid_d;
  logic         err_q, err_d;

  logic         outFree;
  logic         cfgFire;
  logic         dataFire;
  logic         finalWord;
  logic [8:0]   rem;
  logic [511:0] keepMask;
  logic [511:0] oneBit;
  logic [511:0] tailBlock;

  assign outFree            = !outValid_q || bus.data_out_ready;
  assign bus.cfg_in_ready   = (state_q == IDLE) && !sync_rst;
  assign bus.data_in_ready  = (state_q == DATA) && outFree && !sync_rst;
  assign cfgFire            = bus.cfg_in_valid && bus.cfg_in_ready;
  assign dataFire           = bus.data_in_valid && bus.data_in_ready;

  // The final word keeps only its top r message bits, followed by the appended '1'.
  assign rem       = size_q[8:0];
  assign finalWord = (words_q == 55'd1);
  assign keepMask  = ~({512{1'b1}} >> rem);
  assign oneBit    = {1'b1, 511'b0} >> rem;
  assign tailBlock = (bus.data_in & keepMask) | oneBit;

  assign bus.data_out          = outData_q;
  assign bus.data_out_id       = outId_q;
  assign bus.data_out_last     = outLast_q;
  assign bus.data_out_cfg_last = outCfgLast_q;
  assign bus.data_out_valid    = outValid_q;
  assign bus.err               = err_q;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    id_d         = id_q;
    cfgLast_d    = cfgLast_q;
    words_d      = words_q;
    outData_d    = outData_q;
    outId_d      = outId_q;
    outLast_d    = outLast_q;
    outCfgLast_d = outCfgLast_q;
    outValid_d   = outValid_q && !bus.data_out_ready;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (cfgFire) begin
          size_d    = bus.cfg_in_size;
          id_d      = bus.cfg_in_id;
          cfgLast_d = bus.cfg_in_last;
          words_d   = bus.cfg_in_size[63:9] + {54'b0, |bus.cfg_in_size[8:0]};
          state_d   = (bus.cfg_in_size == 64'd0) ? PAD_LEN : DATA;
        end
      end

      DATA: begin
        if (dataFire) begin
          words_d      = words_q - 55'd1;
          outValid_d   = 1'b1;
          outId_d      = id_q;
          outData_d    = bus.data_in;
          outLast_d    = 1'b0;
          outCfgLast_d = 1'b0;
          // data_in_last is only cross-checked against the size count, never obeyed.
          if (bus.data_in_last != finalWord) begin
            err_d = 1'b1;
          end
          if (finalWord) begin
            if (rem == 9'd0) begin
              state_d = PAD_ONE;
            end else if (rem < 9'd448) begin
              outData_d    = {tailBlock[511:64], size_q};
              outLast_d    = 1'b1;
              outCfgLast_d = cfgLast_q;
              state_d      = IDLE;
            end else begin
              outData_d = tailBlock;
              state_d   = PAD_LEN;
            end
          end
        end
      end

      PAD_ONE: begin
        if (outFree) begin
          outValid_d   = 1'b1;
          outId_d      = id_q;
          outData_d    = {1'b1, 447'b0, size_q};
          outLast_d    = 1'b1;
          outCfgLast_d = cfgLast_q;
          state_d      = IDLE;
        end
      end

      PAD_LEN: begin
        // An empty message has no data word to carry the '1', so it lands here.
        if (outFree) begin
          outValid_d   = 1'b1;
          outId_d      = id_q;
          outData_d    = {(size_q == 64'd0), 447'b0, size_q};
          outLast_d    = 1'b1;
          outCfgLast_d = cfgLast_q;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q      <= IDLE;
      size_q       <= '0;
      id_q         <= '0;
      cfgLast_q    <= 1'b0;
      words_q      <= '0;
      outData_q    <= '0;
      outId_q      <= '0;
      outLast_q    <= 1'b0;
      outCfgLast_q <= 1'b0;
      outValid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      id_q         <= id_d;
      cfgLast_q    <= cfgLast_d;
      words_q      <= words_d;
      outData_q    <= outData_d;
      outId_q      <= outId_d;
      outLast_q    <= outLast_d;
      outCfgLast_q <= outCfgLast_d;
      outValid_q   <= outValid_d;
      err_q        <= err_d;
    end
  end

endmodule
